pipe_rx_elastic_buffer: RTL



---
 rtl/pipe_rx_elastic_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_rx_elastic_buffer.sv
// PIPE receive elastic buffer: absorbs clock-rate mismatch by dropping or repeating SKP beats.
// Define EB_STATS_EN to add saturating event counters (stat_added/removed/ovf/unf).
module pipe_rx_elastic_buffer #(
   parameter int unsigned BYTES   = 2,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned MARGIN  = 2,
   parameter logic [7:0]  SKP_SYM = 8'h3C
) (
   input  logic                   phy_pipe_pclk,
   input  logic                   reset_n,
   input  logic [8*BYTES-1:0]     in_data,
   input  logic [BYTES-1:0]       in_datak,
   input  logic                   in_valid,
   input  logic                   rd_en,
   input  logic                   phy_elas_buf_mode,
   output logic [8*BYTES-1:0]     phy_pipe_rx_data,
   output logic [BYTES-1:0]       phy_pipe_rx_datak,
   output logic                   phy_pipe_rx_valid,
   output logic [2:0]             phy_rx_status,
   output logic [$clog2(DEPTH):0] fill_level
`ifdef EB_STATS_EN
   ,
   output logic [15:0]            stat_added,
   output logic [15:0]            stat_removed,
   output logic [15:0]            stat_ovf,
   output logic [15:0]            stat_unf
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef logic [AW:0] fill_t;

   typedef enum logic [2:0] {
      ST_NONE    = 3'b000,
      ST_ADDED   = 3'b001,
      ST_REMOVED = 3'b010,
      ST_OVF     = 3'b101,
      ST_UNF     = 3'b110
   } status_e;

   localparam fill_t LOW_HALF  = fill_t'(DEPTH/2 - MARGIN);
   localparam fill_t HIGH_HALF = fill_t'(DEPTH/2 + MARGIN);
   localparam fill_t HIGH_EMPTY = fill_t'(2*MARGIN);
   localparam fill_t FULL = fill_t'(DEPTH);

   logic [8*BYTES-1:0] mem_data [DEPTH];
   logic [BYTES-1:0]   mem_k    [DEPTH];
   logic [AW-1:0]      wptr, rptr;
   logic               mode_q, last_skp;
   status_e            status_q, status_d;
   fill_t              low_mark, high_mark;
   logic               in_is_skp, head_is_skp;
   logic               wr_remove, wr_ovf, wr_accept;
   logic               rd_add, rd_unf, rd_pop;

   assign low_mark  = mode_q ? '0 : LOW_HALF;
   assign high_mark = mode_q ? HIGH_EMPTY : HIGH_HALF;

   assign in_is_skp   = (&in_datak) && (in_data == {BYTES{SKP_SYM}});
   assign head_is_skp = (&mem_k[rptr]) && (mem_data[rptr] == {BYTES{SKP_SYM}});

   // Both sides judge full/empty on the start-of-cycle fill, so there is no bypass.
   assign wr_remove = in_valid && in_is_skp && (fill_level >= high_mark);
   assign wr_ovf    = in_valid && !wr_remove && (fill_level == FULL);
   assign wr_accept = in_valid && !wr_remove && !wr_ovf;

   assign rd_add = rd_en && last_skp && (fill_level <= low_mark);
   assign rd_unf = rd_en && !rd_add && (fill_level == '0);
   assign rd_pop = rd_en && !rd_add && !rd_unf;

   always_comb begin
      // NOTE: default first so every path assigns status_d and no latch is inferred.
      status_d = ST_NONE;
      if (rd_unf)         status_d = ST_UNF;
      else if (wr_ovf)    status_d = ST_OVF;
      else if (wr_remove) status_d = ST_REMOVED;
      else if (rd_add)    status_d = ST_ADDED;
   end

   // NOTE: storage is deliberately not reset; fill/pointers alone decide what is valid.
   always_ff @(posedge phy_pipe_pclk) begin
      if (reset_n && wr_accept) begin
         mem_data[wptr] <= in_data;
         mem_k[wptr]    <= in_datak;
      end
   end

   // NOTE: non-blocking assignments so every register samples start-of-cycle values.
   always_ff @(posedge phy_pipe_pclk) begin
      if (!reset_n) begin
         wptr              <= '0;
         rptr              <= '0;
         fill_level        <= '0;
         last_skp          <= 1'b0;
         mode_q            <= 1'b0;
         status_q          <= ST_NONE;
         phy_pipe_rx_data  <= '0;
         phy_pipe_rx_datak <= '0;
         phy_pipe_rx_valid <= 1'b0;
      end else begin
         mode_q <= phy_elas_buf_mode;
         if (wr_accept) wptr <= wptr + AW'(1);
         if (rd_pop) begin
            rptr              <= rptr + AW'(1);
            phy_pipe_rx_data  <= mem_data[rptr];
            phy_pipe_rx_datak <= mem_k[rptr];
            last_skp          <= head_is_skp;
         end
         // A repeated SKP leaves the held output beat untouched: it already is that SKP.
         phy_pipe_rx_valid <= rd_pop || rd_add;
         fill_level        <= fill_level + fill_t'(wr_accept) - fill_t'(rd_pop);
         status_q          <= status_d;
      end
   end

   assign phy_rx_status = status_q;

`ifdef EB_STATS_EN
   always_ff @(posedge phy_pipe_pclk) begin
      if (!reset_n) begin
         stat_added   <= '0;
         stat_removed <= '0;
         stat_ovf     <= '0;
         stat_unf     <= '0;
      end else begin
         if (rd_add    && stat_added   != 16'hFFFF) stat_added   <= stat_added   + 16'd1;
         if (wr_remove && stat_removed != 16'hFFFF) stat_removed <= stat_removed + 16'd1;
         if (wr_ovf    && stat_ovf     != 16'hFFFF) stat_ovf     <= stat_ovf     + 16'd1;
         if (rd_unf    && stat_unf     != 16'hFFFF) stat_unf     <= stat_unf     + 16'd1;
      end
   end
`endif

endmodule
